// File: rtl/comm_pkg.sv
// Shared types for the FIFO drain stage: occupancy FSM states and buffer depth.
// No logic; types and constants only.
// Imported by fifo_drain_stage and drain_skid_buf.
package comm_pkg;

  // Occupancy-tracking states of the drain stage output buffer.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  // Entries in the skid buffer; also the credit limit for outstanding FIFO reads.
  localparam int DRAIN_BUF_DEPTH = 2;

endpackage

// File: rtl/drain_skid_buf.sv
// Purpose: 2-entry head/tail word store with shift-on-pop; head is the presented word.
// Latency: a push is visible at head_dat the cycle after it is taken when the store was empty.
// Backpressure: none internally; the caller never pushes into a full store without a pop.
module drain_skid_buf
  import comm_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_dat,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;

  // Next head/tail/occupancy: new words land in the first free slot, pops shift tail into head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_dat;
        else               tail_d = push_dat;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; only the slot receiving the new word differs.
        if (occ_q == 2'(DRAIN_BUF_DEPTH)) begin
          head_d = tail_q;
          tail_d = push_dat;
        end else begin
          head_d = push_dat;
        end
      end
      default: ;
    endcase
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_dat = head_q;
  assign occ      = occ_q;

endmodule

// File: rtl/fifo_drain_stage.sv
// Purpose: pops a registered-read FIFO and re-presents its words as a valid/ready stream
//   (optional DRAIN_STATS_EN adds stat_words/stat_stall counters).
// Latency: rd_en in cycle N gives m_valid in cycle N+2 when the stage is idle.
// Backpressure: reads are credited against buffer space, so a stalled sink holds at most 2 words.
module fifo_drain_stage
  import comm_pkg::*;
#(
  parameter int DATA_WIDTH = 16
`ifdef DRAIN_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  err_underflow
`ifdef DRAIN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_words,
  output logic [CNT_WIDTH-1:0]  stat_stall
`endif
);

  logic       inflight_q, inflight_d;
  logic       err_q, err_d;
  state_e     state_q, state_d;
  logic [1:0] occ;
  logic       push, pop;

  // A read is only issued when the word it returns is guaranteed a buffer slot.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      (({1'b0, occ} + {2'b00, inflight_q}) < 3'(DRAIN_BUF_DEPTH));
  // Words returning from an underflowed read are garbage and never enter the buffer.
  assign push       = inflight_q && !fifo_underflow;
  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid && m_ready;

  drain_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_dat (fifo_data_out),
    .head_dat (m_data),
    .occ      (occ)
  );

  // Occupancy FSM next-state, read-in-flight tracking and sticky underflow flag.
  always_comb begin
    state_d    = state_q;
    inflight_d = fifo_rd_en;
    err_d      = err_q | fifo_underflow;
    case (state_q)
      S_EMPTY: if (push)              state_d = S_ONE;
      S_ONE:   if (push && !pop)      state_d = S_TWO;
               else if (!push && pop) state_d = S_EMPTY;
      S_TWO:   if (!push && pop)      state_d = S_ONE;
      default:                        state_d = S_EMPTY;
    endcase
  end

  // Control registers with synchronous reset; a read in flight at reset is forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign err_underflow = err_q;

  // The credit rule must make a push into a full buffer without a pop unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(state_q == S_TWO && push && !pop));
  // The FSM and the buffer's own count must agree.
  a_state_occ: assert property (@(posedge clk) disable iff (rst)
    occ == 2'(state_q));

`ifdef DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] stat_words_q, stat_words_d;
  logic [CNT_WIDTH-1:0] stat_stall_q, stat_stall_d;

  // Saturating counters of delivered words and sink-stalled cycles.
  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (pop && !(&stat_words_q))                  stat_words_d = stat_words_q + 1'b1;
    if (m_valid && !m_ready && !(&stat_stall_q)) stat_stall_d = stat_stall_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Bench for fifo_drain_stage: behavioural FIFO, occupancy/credit model and in-order scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// DRAIN_STATS_EN, when defined, also exercises the statistics counters.
module tb_fifo_drain_stage;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, fifo_empty, fifo_underflow, fifo_rd_en;
  logic          m_valid, m_ready, err_underflow;
  logic [DW-1:0] fifo_data_out, m_data;
`ifdef DRAIN_STATS_EN
  logic [15:0]   stat_words, stat_stall;
`endif

  always #5 clk = ~clk;

  fifo_drain_stage #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .err_underflow  (err_underflow)
`ifdef DRAIN_STATS_EN
    ,
    .stat_words     (stat_words),
    .stat_stall     (stat_stall)
`endif
  );

  int            checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          lie = 1'b0;   // report non-empty while the FIFO is actually empty
  int            rd_cnt, vld_cnt, first_rd, first_vld, pop_cnt, stall_cnt;
  int            occ_m = 0, infl_m = 0;
  logic          err_m = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_dat;

  task automatic clear_counts();
    rd_cnt = 0; vld_cnt = 0; first_rd = -1; first_vld = -1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: model-vs-DUT checks at negedge, FIFO model update just after posedge.
  task automatic step();
    logic          exp_rd, exp_vld, rd_s;
    logic [DW-1:0] e;
    fifo_empty = (fifo_q.size() == 0) && !lie;
    @(negedge clk);
    exp_rd  = !rst && !fifo_empty && (occ_m + infl_m < 2);
    exp_vld = (occ_m != 0);
    rd_s    = fifo_rd_en;
    checks++;
    if (fifo_rd_en !== exp_rd) begin
      errors++;
      $display("FAIL rd_en cyc=%0d: got %b, required %b", cyc, fifo_rd_en, exp_rd);
    end
    if (rd_s === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (!rst) begin
      checks++;
      if (m_valid !== exp_vld || err_underflow !== err_m) begin
        errors++;
        $display("FAIL vld_err cyc=%0d: m_valid=%b err=%b, required %b %b",
                 cyc, m_valid, err_underflow, exp_vld, err_m);
      end
      if (prev_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_dat) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d: m_valid=%b m_data=%h, required 1 %h",
                   cyc, m_valid, m_data, prev_dat);
        end
      end
      if (m_valid === 1'b1) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        pop_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cyc=%0d: got %h, required no word", cyc, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL data_order cyc=%0d: got %h, required %h", cyc, m_data, e);
          end
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b0) stall_cnt++;
      prev_hold = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_dat  = m_data;
    end else begin
      prev_hold = 1'b0;
    end
    // Reference state advance: buffer count, read in flight, sticky error.
    if (rst) begin
      occ_m = 0; infl_m = 0; err_m = 1'b0;
    end else begin
      occ_m  = occ_m + ((infl_m != 0 && !fifo_underflow) ? 1 : 0) - ((exp_vld && m_ready) ? 1 : 0);
      infl_m = exp_rd ? 1 : 0;
      err_m  = err_m | fifo_underflow;
    end
    cyc++;
    @(posedge clk);
    #1;
    fifo_underflow = 1'b0;
    if (rd_s === 1'b1) begin
      if (fifo_q.size() > 0) begin
        fifo_data_out = fifo_q.pop_front();
      end else begin
        fifo_underflow = 1'b1;
        fifo_data_out  = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    pop_cnt = 0; stall_cnt = 0;
    clear_counts();
  endtask

  task automatic test_reset();
    lie = 1'b1; m_ready = 1'b1; rst = 1'b1;
    clear_counts();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || err_underflow !== 1'b0 || m_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_state: rd_en=%b m_valid=%b err=%b m_data=%h, required 0 0 0 0000",
                 fifo_rd_en, m_valid, err_underflow, m_data);
      end
    end
    checks++;
    if (rd_cnt != 0) begin
      errors++;
      $display("FAIL reset_rd_en: %0d pulses, required 0", rd_cnt);
    end
    lie = 1'b0; rst = 1'b0;
    pop_cnt = 0; stall_cnt = 0;
  endtask

  task automatic test_streaming();
    clear_counts();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) load(16'hA000 + 16'(i));
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (exp_q.size() != 0 || vld_cnt != 4 || rd_cnt != 4) begin
      errors++;
      $display("FAIL stream_count: left=%0d valid=%0d rd=%0d, required 0 4 4", exp_q.size(), vld_cnt, rd_cnt);
    end
    checks++;
    if (first_vld - first_rd != 2) begin
      errors++;
      $display("FAIL stream_latency: %0d cycles, required 2", first_vld - first_rd);
    end
  endtask

  task automatic test_backpressure();
    clear_counts();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(16'($urandom));
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rd_cnt != 2 || dut.occ !== 2'd2 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: rd=%0d occ=%0d rd_en=%b, required 2 2 0", rd_cnt, dut.occ, fifo_rd_en);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d words undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int loaded = 0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0 && loaded < 50) begin
        load(16'($urandom));
        loaded++;
      end
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: %0d words undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_empty_edge();
    clear_counts();
    m_ready = 1'b1;
    load(16'h5A5A);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (rd_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_word: rd=%0d left=%0d, required 1 0", rd_cnt, exp_q.size());
    end
    clear_counts();
    lie = 1'b1;
    step();
    lie = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (err_underflow !== 1'b1 || vld_cnt != 0 || rd_cnt != 1) begin
      errors++;
      $display("FAIL underflow: err=%b valid=%0d rd=%0d, required 1 0 1", err_underflow, vld_cnt, rd_cnt);
    end
  endtask

  task automatic test_midop_reset();
    clear_counts();
    m_ready = 1'b1;
    load(16'hBEEF);
    for (int i = 0; i < 10 && rd_cnt == 0; i++) step();
    checks++;
    if (rd_cnt == 0) begin
      errors++;
      $display("FAIL midop_rd_timeout: no rd_en, required 1");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    clear_counts();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (vld_cnt != 0 || m_valid !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: valid=%0d m_valid=%b err=%b, required 0 0 0", vld_cnt, m_valid, err_underflow);
    end
  endtask

`ifdef DRAIN_STATS_EN
  task automatic test_stats();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(16'($urandom));
    for (int i = 0; i < 10 && vld_cnt == 0; i++) step();
    step();
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (stat_words !== 16'd5 || stat_stall !== 16'd3 ||
        stat_words !== 16'(pop_cnt) || stat_stall !== 16'(stall_cnt)) begin
      errors++;
      $display("FAIL stats: words=%0d stall=%0d, required 5 3 (model %0d %0d)",
               stat_words, stat_stall, pop_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; m_ready = 1'b0; fifo_underflow = 1'b0; fifo_data_out = '0; fifo_empty = 1'b1;
    pop_cnt = 0; stall_cnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_empty_edge();
    test_midop_reset();
`ifdef DRAIN_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
